// File: rtl/shift_left.sv
// Symbol-granular shifter: moves symbols toward the LSB end, filling the MSB end.
// Combinational result plus registered copy and a saturating invalid-shift counter.
module shift_left #(
  parameter int SYMBOL_WIDTH = 12,
  parameter int NUM_SYMBOLS  = 8,
  parameter int VECTOR_WIDTH = SYMBOL_WIDTH * NUM_SYMBOLS,
  parameter int SHIFT_WIDTH  = 3,
  parameter int MAX_SHIFT    = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [VECTOR_WIDTH-1:0] in,
  input  logic [SHIFT_WIDTH-1:0]  shift,
  input  logic [SYMBOL_WIDTH-1:0] fill,
  output logic [VECTOR_WIDTH-1:0] out,
  output logic                    out_valid,
  output logic [VECTOR_WIDTH-1:0] out_q,
  output logic                    out_valid_q,
  output logic [7:0]              invalid_count
);

  logic [VECTOR_WIDTH-1:0] w_out;
  logic                    w_valid;
  logic [VECTOR_WIDTH-1:0] r_out;
  logic                    r_valid;
  logic [7:0]              r_cnt;

  // Symbol j takes fill for j < shift, else input symbol j-shift.
  always_comb begin
    w_out = '0;
    for (int j = 0; j < NUM_SYMBOLS; j++) begin
      if (j < int'(32'(shift))) begin
        w_out[SYMBOL_WIDTH*(NUM_SYMBOLS-1-j) +: SYMBOL_WIDTH] = fill;
      end else begin
        w_out[SYMBOL_WIDTH*(NUM_SYMBOLS-1-j) +: SYMBOL_WIDTH] =
          in[SYMBOL_WIDTH*(NUM_SYMBOLS-1-(j-int'(32'(shift)))) +: SYMBOL_WIDTH];
      end
    end
  end

  assign w_valid = (32'(shift) <= 32'(MAX_SHIFT));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out   <= '0;
      r_valid <= 1'b0;
      r_cnt   <= 8'd0;
    end else begin
      r_out   <= w_out;
      r_valid <= w_valid;
      if (!w_valid && r_cnt != 8'hFF) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign out           = w_out;
  assign out_valid     = w_valid;
  assign out_q         = r_out;
  assign out_valid_q   = r_valid;
  assign invalid_count = r_cnt;

endmodule

// File: tb/tb_shift_left.sv
// Directed self-checking bench for shift_left.
// Inputs change on the falling edge; registered outputs sampled 1 time unit after the rising edge.
module tb_shift_left;

  logic        clk;
  logic        rst;
  logic [95:0] in;
  logic [2:0]  shift;
  logic [11:0] fill;
  logic [95:0] out;
  logic        out_valid;
  logic [95:0] out_q;
  logic        out_valid_q;
  logic [7:0]  invalid_count;

  int errors = 0;
  int checks = 0;

  shift_left dut (
    .clk           (clk),
    .rst           (rst),
    .in            (in),
    .shift         (shift),
    .fill          (fill),
    .out           (out),
    .out_valid     (out_valid),
    .out_q         (out_q),
    .out_valid_q   (out_valid_q),
    .invalid_count (invalid_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] obs,
                     input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic edge_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst   = 1'b1;
    in    = {8{12'h123}};
    shift = 3'd0;
    fill  = 12'h456;
    edge_n(2);
    chk("rst_out_q", out_q, 96'd0);
    chk("rst_valid_q", 96'(out_valid_q), 96'd0);
    chk("rst_count", 96'(invalid_count), 96'd0);

    chk("s0_out", out, {8{12'h123}});
    chk("s0_valid", 96'(out_valid), 96'd1);

    shift = 3'd1; #1;
    chk("s1_out", out, {12'h456, {7{12'h123}}});
    chk("s1_valid", 96'(out_valid), 96'd1);

    shift = 3'd5; #1;
    chk("s5_out", out, {{5{12'h456}}, {3{12'h123}}});
    chk("s5_valid", 96'(out_valid), 96'd1);

    in    = 96'h000_111_222_333_444_555_666_777;
    shift = 3'd2;
    fill  = 12'hFFF; #1;
    chk("dir_out", out, 96'hFFF_FFF_000_111_222_333_444_555);
    chk("dir_valid", 96'(out_valid), 96'd1);

    in   = {8{12'h800}};
    fill = 12'h000; #1;
    chk("s2_zero_fill", out, {{2{12'h000}}, {6{12'h800}}});

    in    = {8{12'h123}};
    fill  = 12'h456;
    shift = 3'd6; #1;
    chk("s6_valid", 96'(out_valid), 96'd0);
    chk("s6_out", out, {{6{12'h456}}, {2{12'h123}}});
    shift = 3'd7; #1;
    chk("s7_valid", 96'(out_valid), 96'd0);
    chk("s7_out", out, {{7{12'h456}}, 12'h123});

    // invalid shift held under reset must not count
    edge_n(1);
    chk("rst_hold_count", 96'(invalid_count), 96'd0);
    chk("rst_hold_out_q", out_q, 96'd0);

    @(negedge clk);
    rst   = 1'b0;
    in    = {8{12'hABC}};
    shift = 3'd3;
    fill  = 12'hDEF;
    edge_n(1);
    chk("cap_out_q", out_q, {{3{12'hDEF}}, {5{12'hABC}}});
    chk("cap_valid_q", 96'(out_valid_q), 96'd1);
    chk("cap_count", 96'(invalid_count), 96'd0);

    @(negedge clk);
    shift = 3'd7;
    edge_n(1);
    chk("inv_out_q", out_q, {{7{12'hDEF}}, 12'hABC});
    chk("inv_valid_q", 96'(out_valid_q), 96'd0);
    chk("cnt_1", 96'(invalid_count), 96'd1);
    edge_n(253);
    chk("cnt_254", 96'(invalid_count), 96'd254);
    edge_n(1);
    chk("cnt_255", 96'(invalid_count), 96'd255);
    edge_n(45);
    chk("cnt_sat", 96'(invalid_count), 96'd255);

    @(negedge clk);
    rst = 1'b1;
    edge_n(1);
    chk("mid_rst_count", 96'(invalid_count), 96'd0);
    chk("mid_rst_out_q", out_q, 96'd0);
    chk("mid_rst_valid_q", 96'(out_valid_q), 96'd0);

    @(negedge clk);
    rst = 1'b0;
    edge_n(1);
    chk("post_rst_count", 96'(invalid_count), 96'd1);
    chk("post_rst_out_q", out_q, {{7{12'hDEF}}, 12'hABC});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
